// File: rtl/snake_renderer.sv
// Snake frame renderer: erases last frame's tail, then plots one pixel per valid segment to the VGA adapter.
// Optional perimeter border drawn after the body when SNAKE_RENDER_BORDER_EN is defined.
module snake_renderer #(
    parameter int unsigned LENGTH      = 100,
    parameter logic [2:0]  HEAD_COLOUR = 3'b010,
    parameter logic [2:0]  BODY_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
`ifdef SNAKE_RENDER_BORDER_EN
    ,
    parameter logic [2:0]  BORDER_COLOUR = 3'b111
`endif
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] seg_x,
    input  logic [6:0] seg_y,
    input  logic       seg_valid,
    output logic [6:0] j,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned J_W = 7;
    localparam logic [J_W-1:0] J_LAST = J_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
`ifdef SNAKE_RENDER_BORDER_EN
        S_BORDER,
`endif
        S_DONE
    } state_t;

    state_t         state;
    logic           have_tail;
    logic [X_W-1:0] tail_x;
    logic [Y_W-1:0] tail_y;

`ifdef SNAKE_RENDER_BORDER_EN
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned X_MAX      = 159;
    localparam int unsigned Y_MAX      = 119;
    localparam int unsigned ROW_PIX    = X_MAX + 1;
    localparam int unsigned COL_PIX    = Y_MAX + 1;
    localparam int unsigned BORDER_PIX = 2 * ROW_PIX + 2 * COL_PIX;

    logic [CNT_W-1:0] bord_cnt;
    logic [X_W-1:0]   border_x_c;
    logic [Y_W-1:0]   border_y_c;

    // Perimeter walk: top row, bottom row, left column, right column
    always_comb begin
        border_x_c = '0;
        border_y_c = '0;
        if (bord_cnt < CNT_W'(ROW_PIX)) begin
            border_x_c = X_W'(bord_cnt);
        end else if (bord_cnt < CNT_W'(2 * ROW_PIX)) begin
            border_x_c = X_W'(bord_cnt - CNT_W'(ROW_PIX));
            border_y_c = Y_W'(Y_MAX);
        end else if (bord_cnt < CNT_W'(2 * ROW_PIX + COL_PIX)) begin
            border_y_c = Y_W'(bord_cnt - CNT_W'(2 * ROW_PIX));
        end else begin
            border_x_c = X_W'(X_MAX);
            border_y_c = Y_W'(bord_cnt - CNT_W'(2 * ROW_PIX + COL_PIX));
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= S_IDLE;
            j          <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            have_tail  <= 1'b0;
            tail_x     <= '0;
            tail_y     <= '0;
`ifdef SNAKE_RENDER_BORDER_EN
            bord_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                    // A start overlapping the done pulse belongs to the finished frame
                    if (start && !done) begin
                        busy  <= 1'b1;
                        j     <= '0;
                        state <= S_DRAW;
                        if (have_tail) begin
                            vga_x      <= tail_x;
                            vga_y      <= tail_y;
                            vga_colour <= BG_COLOUR;
                            vga_plot   <= 1'b1;
                        end
                    end
                end

                S_DRAW: begin
                    vga_x      <= seg_x;
                    vga_y      <= seg_y;
                    vga_plot   <= seg_valid;
                    vga_colour <= (j == '0) ? HEAD_COLOUR : BODY_COLOUR;
                    if (seg_valid) begin
                        tail_x    <= seg_x;
                        tail_y    <= seg_y;
                        have_tail <= 1'b1;
                    end
                    // Valid slots are contiguous from 0, so the first invalid slot ends the sweep
                    if (!seg_valid || j == J_LAST) begin
                        j <= '0;
`ifdef SNAKE_RENDER_BORDER_EN
                        bord_cnt <= '0;
                        state    <= S_BORDER;
`else
                        state    <= S_DONE;
`endif
                    end else begin
                        j <= j + J_W'(1);
                    end
                end

`ifdef SNAKE_RENDER_BORDER_EN
                S_BORDER: begin
                    vga_x      <= border_x_c;
                    vga_y      <= border_y_c;
                    vga_colour <= BORDER_COLOUR;
                    vga_plot   <= 1'b1;
                    if (bord_cnt == CNT_W'(BORDER_PIX - 1)) begin
                        state <= S_DONE;
                    end else begin
                        bord_cnt <= bord_cnt + CNT_W'(1);
                    end
                end
`endif

                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    vga_plot <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_renderer.sv
// Scoreboard bench for snake_renderer: stimulus queues expected pixels, a negedge monitor checks each plot.
module tb_snake_renderer;

    localparam int LEN = 100;
    localparam logic [2:0] C_HEAD = 3'b010;
    localparam logic [2:0] C_BODY = 3'b110;
    localparam logic [2:0] C_BG   = 3'b000;
`ifdef SNAKE_RENDER_BORDER_EN
    localparam int BORD = 560;
`else
    localparam int BORD = 0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] seg_x;
    logic [6:0] seg_y;
    logic       seg_valid;
    logic [6:0] j;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    logic [7:0] xs [128];
    logic [6:0] ys [128];
    int         nvalid = 0;

    assign seg_x     = xs[j];
    assign seg_y     = ys[j];
    assign seg_valid = (int'(j) < nvalid);

    snake_renderer dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .seg_valid  (seg_valid),
        .j          (j),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       sb[$];
    pix_t       exp_pix;
    int         errors = 0;
    int         checks = 0;
    int         max_j  = 0;
    bit         have_tail_m = 1'b0;
    logic [7:0] tx;
    logic [6:0] ty;

    // Monitor: every plotted pixel must match the head of the expected queue
    always @(negedge clock) begin
        if (resetn === 1'b1 && vga_plot === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d) c=%b, required no plot", vga_x, vga_y, vga_colour);
            end else begin
                exp_pix = sb.pop_front();
                if (vga_x !== exp_pix.x || vga_y !== exp_pix.y || vga_colour !== exp_pix.c) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d) c=%b, required (%0d,%0d) c=%b",
                             vga_x, vga_y, vga_colour, exp_pix.x, exp_pix.y, exp_pix.c);
                end
            end
        end
        if (busy === 1'b1 && int'(j) > max_j) max_j = int'(j);
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        sb.push_back(p);
    endtask

    task automatic push_frame(input int n);
        if (have_tail_m) push_pix(tx, ty, C_BG);
        for (int i = 0; i < n; i++) push_pix(xs[i], ys[i], (i == 0) ? C_HEAD : C_BODY);
`ifdef SNAKE_RENDER_BORDER_EN
        for (int k = 0; k < 160; k++) push_pix(8'(k), 7'd0, 3'b111);
        for (int k = 0; k < 160; k++) push_pix(8'(k), 7'd119, 3'b111);
        for (int k = 0; k < 120; k++) push_pix(8'd0, 7'(k), 3'b111);
        for (int k = 0; k < 120; k++) push_pix(8'd159, 7'(k), 3'b111);
`endif
        nvalid = n;
    endtask

    task automatic issue_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit pulse_busy, input bit pulse_done);
        int cyc;
        push_frame(n);
        issue_start();
        check("busy_after_start", int'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            start = (pulse_busy && cyc == 2);
            @(posedge clock);
            #1 cyc++;
        end
        start = 1'b0;
        check("done_latency", cyc, ((n < LEN) ? n + 2 : LEN + 1) + BORD);
        check("busy_at_done", int'(busy), 0);
        check("queue_drained", sb.size(), 0);
        if (pulse_done) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        if (pulse_done) begin
            repeat (4) begin
                check("no_restart_busy", int'(busy), 0);
                @(posedge clock);
                #1;
            end
        end
        if (n > 0) begin
            have_tail_m = 1'b1;
            tx = xs[n-1];
            ty = ys[n-1];
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_j"}, int'(j), 0);
        check({tag, "_vga_x"}, int'(vga_x), 0);
        check({tag, "_vga_y"}, int'(vga_y), 0);
        check({tag, "_colour"}, int'(vga_colour), 0);
        check({tag, "_plot"}, int'(vga_plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int wait_cyc;
        for (int i = 0; i < 128; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_zero("reset");
        @(negedge clock);
        resetn = 1'b1;

        // T1: ten segments heading left from (80,60), no erase
        for (int i = 0; i < 10; i++) begin
            xs[i] = 8'(80 - i);
            ys[i] = 7'd60;
        end
        run_frame(10, 1'b0, 1'b0);

        // T2: shifted right by one; erase of (71,60) comes first
        for (int i = 0; i < 10; i++) xs[i] = 8'(81 - i);
        run_frame(10, 1'b0, 1'b0);

        // T3: full array
        for (int i = 0; i < LEN; i++) begin
            xs[i] = 8'(i);
            ys[i] = 7'(100 - i);
        end
        max_j = 0;
        run_frame(LEN, 1'b0, 1'b0);
        check("max_j", max_j, LEN - 1);

        // T4: start pulsed while busy and on the done cycle, then a normal restart
        for (int i = 0; i < 3; i++) begin
            xs[i] = 8'(10 + i);
            ys[i] = 7'd20;
        end
        run_frame(3, 1'b1, 1'b1);
        run_frame(3, 1'b0, 1'b0);

        // Zero valid segments: erase only, tail kept
        run_frame(0, 1'b0, 1'b0);

        // T5: reset mid-frame at j=5
        for (int i = 0; i < 10; i++) begin
            xs[i] = 8'(40 + i);
            ys[i] = 7'd30;
        end
        push_frame(10);
        issue_start();
        wait_cyc = 0;
        while (j !== 7'd5 && wait_cyc < 50) begin
            @(posedge clock);
            #1 wait_cyc++;
        end
        check("reach_j5", int'(j), 5);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1 check_zero("midreset");
        sb.delete();
        have_tail_m = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        run_frame(10, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1 check("final_queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
